// File: rtl/othello_pkg.sv
// Shared Othello types: cell codes, board layout, the flipper state enum and the
// eight-way direction delta table (N, NE, E, SE, S, SW, W, NW).
package othello_pkg;

    typedef logic [1:0] cell_t;

    localparam cell_t CELL_BLACK = 2'd0;
    localparam cell_t CELL_WHITE = 2'd1;
    localparam cell_t CELL_EMPTY = 2'd2;

    // Board is indexed [row][col]; code 3 marks an invalid (blocked) cell.
    typedef cell_t [0:7][0:7] board_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_DIR,
        ST_SCAN,
        ST_FLIP,
        ST_FINISH
    } flip_state_t;

    localparam logic signed [1:0] DIR_DR [0:7] =
        '{2'sb11, 2'sb11, 2'sb00, 2'sb01, 2'sb01, 2'sb01, 2'sb00, 2'sb11};
    localparam logic signed [1:0] DIR_DC [0:7] =
        '{2'sb00, 2'sb01, 2'sb01, 2'sb01, 2'sb00, 2'sb11, 2'sb11, 2'sb11};

endpackage

// File: rtl/ray_step.sv
// One step along a direction from (row, col); flags steps that leave the board.
// Coordinates are widened to 4-bit signed so -1 and 8 both land with bit 3 set.
module ray_step
    import othello_pkg::*;
(
    input  logic [2:0] row,
    input  logic [2:0] col,
    input  logic [2:0] dir,
    output logic [2:0] next_row,
    output logic [2:0] next_col,
    output logic       off_board
);

    logic signed [3:0] sum_row;
    logic signed [3:0] sum_col;

    always_comb begin
        sum_row   = $signed({1'b0, row}) + $signed({{2{DIR_DR[dir][1]}}, DIR_DR[dir]});
        sum_col   = $signed({1'b0, col}) + $signed({{2{DIR_DC[dir][1]}}, DIR_DC[dir]});
        next_row  = sum_row[2:0];
        next_col  = sum_col[2:0];
        off_board = sum_row[3] | sum_col[3];
    end

endmodule

// File: rtl/move_flipper.sv
// Evaluates one Othello move: scans the eight rays from the target one cell per
// cycle, flips bracketed opponent stones in a working copy and reports the count.
module move_flipper
    import othello_pkg::*;
#(
    parameter int FLIP_W = 5
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_color,
    input  logic [2:0]        i_row,
    input  logic [2:0]        i_col,
    input  board_t            i_current_board,
    output board_t            o_updated_board,
    output logic [FLIP_W-1:0] o_flip,
    output logic              o_done
);

    flip_state_t       state;
    flip_state_t       next_state;
    board_t            work;
    board_t            final_board;
    logic              color;
    logic [2:0]        row;
    logic [2:0]        col;
    logic [2:0]        dir;
    logic [2:0]        cur_row;
    logic [2:0]        cur_col;
    logic [2:0]        run;
    logic [FLIP_W-1:0] total;
    logic [FLIP_W:0]   sum;
    logic [FLIP_W-1:0] total_sat;

    logic [2:0] step_row_in;
    logic [2:0] step_col_in;
    logic [2:0] step_dir;
    logic [2:0] step_row;
    logic [2:0] step_col;
    logic       step_off;

    cell_t own;
    cell_t opp;
    cell_t cell_here;
    logic  last_dir;

    assign own       = color ? CELL_WHITE : CELL_BLACK;
    assign opp       = color ? CELL_BLACK : CELL_WHITE;
    assign cell_here = work[cur_row][cur_col];
    assign last_dir  = (dir == 3'd7);

    assign sum       = {1'b0, total} + (FLIP_W+1)'(run);
    assign total_sat = sum[FLIP_W] ? '1 : sum[FLIP_W-1:0];

    // DIR steps from the target; FLIP walks back by using the opposite direction (dir ^ 4).
    always_comb begin
        step_row_in = cur_row;
        step_col_in = cur_col;
        step_dir    = dir;
        if (state == ST_DIR) begin
            step_row_in = row;
            step_col_in = col;
        end else if (state == ST_FLIP) begin
            step_dir = dir ^ 3'd4;
        end
    end

    ray_step u_ray_step (
        .row      (step_row_in),
        .col      (step_col_in),
        .dir      (step_dir),
        .next_row (step_row),
        .next_col (step_col),
        .off_board(step_off)
    );

    always_comb begin
        final_board = work;
        if (total != '0) begin
            final_board[row][col] = own;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (i_start) next_state = ST_CHECK;
            end
            ST_CHECK: begin
                next_state = (work[row][col] != CELL_EMPTY) ? ST_FINISH : ST_DIR;
            end
            ST_DIR: begin
                if (!step_off)     next_state = ST_SCAN;
                else if (last_dir) next_state = ST_FINISH;
            end
            ST_SCAN: begin
                if (cell_here == opp) begin
                    if (step_off) next_state = last_dir ? ST_FINISH : ST_DIR;
                end else if (cell_here == own && run != 3'd0) begin
                    next_state = ST_FLIP;
                end else begin
                    next_state = last_dir ? ST_FINISH : ST_DIR;
                end
            end
            ST_FLIP: begin
                if (run == 3'd1) next_state = last_dir ? ST_FINISH : ST_DIR;
            end
            ST_FINISH: next_state = ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            work            <= '0;
            color           <= 1'b0;
            row             <= '0;
            col             <= '0;
            dir             <= '0;
            cur_row         <= '0;
            cur_col         <= '0;
            run             <= '0;
            total           <= '0;
            o_updated_board <= '0;
            o_flip          <= '0;
            o_done          <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        work  <= i_current_board;
                        color <= i_color;
                        row   <= i_row;
                        col   <= i_col;
                        dir   <= '0;
                        run   <= '0;
                        total <= '0;
                    end
                end
                ST_CHECK: begin
                    total <= '0;
                    dir   <= '0;
                end
                ST_DIR: begin
                    if (step_off) begin
                        if (!last_dir) dir <= dir + 3'd1;
                    end else begin
                        cur_row <= step_row;
                        cur_col <= step_col;
                        run     <= '0;
                    end
                end
                ST_SCAN: begin
                    if (cell_here == opp) begin
                        run <= run + 3'd1;
                        if (step_off) begin
                            if (!last_dir) dir <= dir + 3'd1;
                        end else begin
                            cur_row <= step_row;
                            cur_col <= step_col;
                        end
                    end else if (cell_here == own && run != 3'd0) begin
                        total <= total_sat;
                    end else if (!last_dir) begin
                        dir <= dir + 3'd1;
                    end
                end
                ST_FLIP: begin
                    work[step_row][step_col] <= own;
                    cur_row <= step_row;
                    cur_col <= step_col;
                    run     <= run - 3'd1;
                    if (run == 3'd1 && !last_dir) dir <= dir + 3'd1;
                end
                ST_FINISH: begin
                    work            <= final_board;
                    o_updated_board <= final_board;
                    o_flip          <= total;
                    o_done          <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_move_flipper.sv
// Bench for move_flipper: directed and random moves checked against a ray-walking
// reference model through an expected-result queue drained on each done pulse.
module tb_move_flipper;
    import othello_pkg::*;

    localparam int FLIP_W = 5;
    localparam int W      = FLIP_W + 128;
    localparam int BUDGET = 500;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              color;
    logic [2:0]        row;
    logic [2:0]        col;
    board_t            cur_board;
    board_t            upd_board;
    logic [FLIP_W-1:0] flip;
    logic              done;

    logic [W-1:0] exp_q[$];
    int checks     = 0;
    int passed     = 0;
    int done_count = 0;

    move_flipper #(.FLIP_W(FLIP_W)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_start        (start),
        .i_color        (color),
        .i_row          (row),
        .i_col          (col),
        .i_current_board(cur_board),
        .o_updated_board(upd_board),
        .o_flip         (flip),
        .o_done         (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference: walk each ray with integer coordinates, flip bracketed opponent runs.
    function automatic logic [W-1:0] model(input board_t b, input logic c, input int tr, input int tc);
        int    drs [8] = '{-1, -1, 0, 1, 1, 1, 0, -1};
        int    dcs [8] = '{0, 1, 1, 1, 0, -1, -1, -1};
        board_t res   = b;
        int    total  = 0;
        cell_t mine   = c ? CELL_WHITE : CELL_BLACK;
        cell_t theirs = c ? CELL_BLACK : CELL_WHITE;
        logic [FLIP_W-1:0] f;
        if (b[tr][tc] == CELL_EMPTY) begin
            for (int d = 0; d < 8; d++) begin
                int n = 0;
                int r = tr + drs[d];
                int k = tc + dcs[d];
                while (r >= 0 && r <= 7 && k >= 0 && k <= 7 && b[r][k] == theirs) begin
                    n++;
                    r += drs[d];
                    k += dcs[d];
                end
                if (n > 0 && r >= 0 && r <= 7 && k >= 0 && k <= 7 && b[r][k] == mine) begin
                    for (int s = 1; s <= n; s++) res[tr + s*drs[d]][tc + s*dcs[d]] = mine;
                    total += n;
                end
            end
        end
        if (total > 0) res[tr][tc] = mine;
        if (total > (1 << FLIP_W) - 1) total = (1 << FLIP_W) - 1;
        f = total[FLIP_W-1:0];
        return {f, res};
    endfunction

    function automatic board_t empty_board();
        board_t b;
        for (int r = 0; r < 8; r++)
            for (int k = 0; k < 8; k++) b[r][k] = CELL_EMPTY;
        return b;
    endfunction

    function automatic board_t opening_board();
        board_t b = empty_board();
        b[3][3] = CELL_WHITE; b[4][4] = CELL_WHITE;
        b[3][4] = CELL_BLACK; b[4][3] = CELL_BLACK;
        return b;
    endfunction

    function automatic board_t cross_board();
        board_t b = empty_board();
        b[4][5] = CELL_WHITE; b[4][6] = CELL_WHITE; b[3][4] = CELL_WHITE;
        b[2][4] = CELL_WHITE; b[5][5] = CELL_WHITE;
        b[4][7] = CELL_BLACK; b[1][4] = CELL_BLACK; b[6][6] = CELL_BLACK;
        return b;
    endfunction

    // Monitor: every done pulse must match the oldest expected result.
    always @(negedge clk) begin
        if (rst_n && done) begin
            done_count++;
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_done: got done=1 with no request outstanding, expected none");
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                check("flip", W'(flip), W'(e[W-1:128]));
                check("board", W'(upd_board), W'(e[127:0]));
            end
        end
    end

    task automatic drive_start(input board_t b, input logic c, input int r, input int k);
        @(negedge clk);
        cur_board = b;
        color     = c;
        row       = 3'(r);
        col       = 3'(k);
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic do_move(input board_t b, input logic c, input int r, input int k, output int lat);
        exp_q.push_back(model(b, c, r, k));
        drive_start(b, c, r, k);
        lat = 0;
        while (!done && lat < BUDGET) begin
            @(negedge clk);
            lat++;
        end
        if (!done) begin
            checks++;
            $display("FAIL done_timeout: got no done in %0d cycles, expected a done pulse", BUDGET);
            exp_q.delete();
        end else begin
            @(negedge clk);
            check("done_width", W'(done), W'(0));
        end
    endtask

    task automatic wait_state(input flip_state_t st, output logic hit);
        int n = 0;
        hit = 1'b0;
        while (n < BUDGET && !hit) begin
            @(negedge clk);
            hit = (dut.state == st);
            n++;
        end
        if (!hit) begin
            checks++;
            $display("FAIL wait_state: got no entry to state %0d, expected entry", st);
        end
    endtask

    initial begin
        int     lat;
        int     d0;
        logic   hit;
        board_t b;

        rst_n = 1'b0; start = 1'b0; color = 1'b0; row = '0; col = '0;
        cur_board = empty_board();
        repeat (3) @(negedge clk);
        check("reset_done", W'(done), W'(0));
        check("reset_flip", W'(flip), W'(0));
        check("reset_board", W'(upd_board), W'(0));
        rst_n = 1'b1;

        do_move(opening_board(), 1'b0, 2, 3, lat);
        check("open_flip_const", W'(flip), W'(1));
        check("open_cell33", W'(upd_board[3][3]), W'(CELL_BLACK));

        do_move(opening_board(), 1'b0, 3, 3, lat);
        check("occupied_latency", W'(lat), W'(2));

        do_move(opening_board(), 1'b0, 0, 0, lat);

        do_move(cross_board(), 1'b0, 4, 4, lat);
        check("cross_flip_const", W'(flip), W'(5));

        b = empty_board();
        for (int k = 1; k < 8; k++) b[0][k] = CELL_WHITE;
        do_move(b, 1'b0, 0, 0, lat);

        // A second start while scanning must not produce a second result.
        d0 = done_count;
        exp_q.push_back(model(opening_board(), 1'b0, 2, 3));
        drive_start(opening_board(), 1'b0, 2, 3);
        wait_state(ST_SCAN, hit);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (200) @(negedge clk);
        check("midscan_single_done", W'(done_count - d0), W'(1));

        // Reset while flipping clears outputs at once and suppresses done.
        d0 = done_count;
        drive_start(cross_board(), 1'b0, 4, 4);
        wait_state(ST_FLIP, hit);
        #1 rst_n = 1'b0;
        #1;
        check("rst_flip_flip", W'(flip), W'(0));
        check("rst_flip_board", W'(upd_board), W'(0));
        check("rst_flip_done", W'(done), W'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        check("rst_no_done", W'(done_count - d0), W'(0));

        do_move(cross_board(), 1'b0, 4, 4, lat);

        for (int t = 0; t < 60; t++) begin
            int r = $urandom_range(0, 7);
            int k = $urandom_range(0, 7);
            for (int i = 0; i < 8; i++) begin
                for (int j = 0; j < 8; j++) begin
                    int v = $urandom_range(0, 9);
                    b[i][j] = (v < 3) ? CELL_BLACK : (v < 6) ? CELL_WHITE : (v < 9) ? CELL_EMPTY : 2'd3;
                end
            end
            if ($urandom_range(0, 1) == 1) b[r][k] = CELL_EMPTY;
            do_move(b, 1'($urandom_range(0, 1)), r, k, lat);
        end

        repeat (5) @(negedge clk);
        check("queue_drained", W'(exp_q.size()), W'(0));
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
